merge_ctrl: RTL and testbench
=============================

# merge_ctrl

Sequencing controller for a 16-input merge datapath. It generates a registered 4-bit select index, with a qualifying valid, that steps round-robin through a programmable number of inputs. It holds each input for a programmable number of cycles and stops after a programmed total number of output words. It sits between the Versat configuration/run fabric and the merge mux. It replaces the free-running internal counter with a bounded, stallable and restartable schedule that reports completion on `done`.

## Interface
- `DELAY_W`, 32, width of the start-delay count
- `HOLD_W`, 8, width of the per-input hold count
- `LEN_W`, 16, width of the total output-word count
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `run`  in  1  single-cycle start pulse; latches configuration and (re)starts the schedule
- `stall`  in  1  freezes all counters while high
- `delay0`  in  DELAY_W  cycles to wait after `run` before the first valid select
- `nin`  in  4  index of the last input used (inputs 0..nin are visited)
- `hold`  in  HOLD_W  cycles per input minus 1 (0 = one cycle per input)
- `length`  in  LEN_W  total valid select cycles to issue; 0 = none
- `sel`  out  4  current input index for the merge mux
- `sel_valid`  out  1  high in each cycle where `sel` is a scheduled output slot
- `done`  out  1  high when idle or finished; low while a schedule is pending

## Operation
- Configuration (`delay0`, `nin`, `hold`, `length`) is captured only on a clock edge with `run`=1. Later input changes are ignored until the next `run`.
- States:
  - IDLE (reset state)
  - DELAY (counting down the start delay)
  - ACTIVE (issuing slots)
- `run`=1 in any state:
  - Clears the index, hold and length counters.
  - Next state is DELAY with dcnt=delay0 if delay0≠0.
  - Next state is ACTIVE if delay0=0 and length≠0.
  - Next state is IDLE if length=0.
  - A `run` during DELAY or ACTIVE aborts the current schedule and restarts; there is no extra done pulse.
- DELAY: dcnt decrements each unstalled cycle. On the edge where dcnt=1, go to ACTIVE, or to IDLE if length=0.
- ACTIVE, each unstalled cycle:
  - The slot at index `sel` is issued and the length counter increments.
  - The hold counter increments. When it equals the latched hold, the hold counter clears and the index advances.
  - Index wrap: after index = nin, the next index is 0. With nin=0 the index stays 0.
  - When the issued count reaches length, go to IDLE.
- Stall: `stall`=1 freezes dcnt, index, hold and length counters and the state. `sel` holds its value and `sel_valid`=0.
- Priority: `rst` > `run` > `stall`. Both `run` and `stall` high means restart.
- Arithmetic: all counters are unsigned. Compares are equality against latched values, so no overflow is possible. length up to 2^LEN_W−1 is supported.

## Timing
- Reset values: `sel`=0, `sel_valid`=0, `done`=1, state IDLE, all counters 0.
- `rst` asserted mid-schedule forces the reset values immediately, asynchronously.
- All outputs are registered: `sel_valid` = (state==ACTIVE && !stall), and `done` = (state==IDLE).
- Timing is measured from the edge E where `run`=1:
  - `done`=0 from cycle E+1 (unless length=0).
  - The first `sel_valid` is in cycle E+1+delay0, assuming no stalls.
  - Each stall cycle adds one cycle of latency.
- Slot order: each index appears for hold+1 consecutive unstalled valid cycles. `sel` changes on the edge after the last hold cycle.
- Last slot: `sel_valid` is high in the cycle of slot number `length`. In the following cycle `done`=1 and `sel_valid`=0.
- length=0:
  - If delay0=0, `done` stays 1 (or returns to 1 at E+1) and `sel_valid` is never asserted.
  - If delay0≠0, `done` goes low for delay0 cycles and then returns to 1 with no valid slot.
- `sel` after completion holds its last advanced value until the next `run`, which clears it to 0 at E+1.

## Test plan
- Reset then idle: assert `rst`, then release with `run`=0 for 20 cycles -> `done`=1, `sel_valid`=0, `sel`=0 throughout.
- Basic schedule: delay0=3, nin=3, hold=1, length=10 -> first valid at E+4; `sel` sequence 0,0,1,1,2,2,3,3,0,0; `done`=1 in the cycle after the 10th slot.
- Stall and wrap: delay0=0, nin=15, hold=0, length=20, `stall` high for 2 cycles at slot 5 -> `sel` runs 0..15,0..3 with a 2-cycle valid gap; `sel` holds at 5 during the gap; done is 2 cycles later than unstalled.
- Restart mid-run: `run` again during slot 4 with nin=1, hold=0, length=3, delay0=0 -> `sel` sequence 0,1,0 starting the cycle after the second `run`; no `done` pulse between the two schedules.
- Degenerate configuration: length=0 with delay0=0 -> `done` stays 1 and no `sel_valid`; then nin=0, hold=255, length=256 -> 256 valid cycles all with `sel`=0.
- Asynchronous reset mid-DELAY and mid-ACTIVE: pulse `rst` between clock edges -> outputs return to the reset values before the next edge, and the subsequent `run` behaves as from power-up.

Source files
------------

// File: rtl/merge_if.sv
// Handshake/config bundle between the run fabric and merge_ctrl.
interface merge_if #(
  parameter int DELAY_W = 32,
  parameter int HOLD_W  = 8,
  parameter int LEN_W   = 16
);
  logic               run;
  logic               stall;
  logic [DELAY_W-1:0] delay0;
  logic [3:0]         nin;
  logic [HOLD_W-1:0]  hold;
  logic [LEN_W-1:0]   length;
  logic [3:0]         sel;
  logic               sel_valid;
  logic               done;

  modport master (output run, stall, delay0, nin, hold, length,
                  input  sel, sel_valid, done);
  modport slave  (input  run, stall, delay0, nin, hold, length,
                  output sel, sel_valid, done);
endinterface

// File: rtl/merge_ctrl.sv
// Bounded round-robin select sequencer for a 16-input merge mux.
// Each unstalled edge in ACTIVE retires the slot just shown and issues the next one.
module merge_ctrl #(
  parameter int DELAY_W = 32,
  parameter int HOLD_W  = 8,
  parameter int LEN_W   = 16
) (
  input  logic    clk,
  input  logic    rst,
  merge_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;

  typedef struct packed {
    logic [3:0]        nin;
    logic [HOLD_W-1:0] hold;
    logic [LEN_W-1:0]  len;
  } cfg_t;

  state_t             state;
  cfg_t               cfg;
  logic [DELAY_W-1:0] dcnt;
  logic [HOLD_W-1:0]  hcnt;
  logic [LEN_W-1:0]   lcnt;
  logic [3:0]         sel_q;
  logic               valid_q;
  logic               done_q;

  assign bus.sel       = sel_q;
  assign bus.sel_valid = valid_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cfg     <= '0;
      dcnt    <= '0;
      hcnt    <= '0;
      lcnt    <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b1;
    end else if (bus.run) begin
      cfg   <= '{nin: bus.nin, hold: bus.hold, len: bus.length};
      hcnt  <= '0;
      sel_q <= '0;
      dcnt  <= bus.delay0;
      if (bus.delay0 != '0) begin
        state   <= DELAY;
        lcnt    <= '0;
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end else if (bus.length != '0) begin
        // first slot is issued straight from the run edge
        state   <= ACTIVE;
        lcnt    <= LEN_W'(1);
        valid_q <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        state   <= IDLE;
        lcnt    <= '0;
        valid_q <= 1'b0;
        done_q  <= 1'b1;
      end
    end else if (bus.stall) begin
      valid_q <= 1'b0;
    end else begin
      case (state)
        DELAY: begin
          if (dcnt == DELAY_W'(1)) begin
            dcnt <= '0;
            if (cfg.len == '0) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state   <= ACTIVE;
              lcnt    <= LEN_W'(1);
              valid_q <= 1'b1;
            end
          end else begin
            dcnt <= dcnt - DELAY_W'(1);
          end
        end
        ACTIVE: begin
          // retire the slot just shown; index moves even on the final slot
          if (hcnt == cfg.hold) begin
            hcnt  <= '0;
            sel_q <= (sel_q == cfg.nin) ? 4'd0 : sel_q + 4'd1;
          end else begin
            hcnt <= hcnt + HOLD_W'(1);
          end
          if (lcnt == cfg.len) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            lcnt    <= lcnt + LEN_W'(1);
            valid_q <= 1'b1;
          end
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_merge_ctrl.sv
// Directed bench for merge_ctrl: schedules, stall gap, restart, degenerate configs, async reset.
module tb_merge_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   nchk  = 0;
  int   nfail = 0;

  merge_if #(.DELAY_W(32), .HOLD_W(8), .LEN_W(16)) mif ();
  merge_ctrl #(.DELAY_W(32), .HOLD_W(8), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(mif.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic v, input logic [3:0] s, input logic d);
    chk({tag, ".valid"}, 32'(mif.sel_valid), 32'(v));
    chk({tag, ".sel"},   32'(mif.sel),       32'(s));
    chk({tag, ".done"},  32'(mif.done),      32'(d));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pulse run for one edge; afterwards we sit in cycle E+1
  task automatic start(input logic [31:0] d0, input logic [3:0] n, input logic [7:0] h,
                       input logic [15:0] l);
    mif.delay0 = d0; mif.nin = n; mif.hold = h; mif.length = l; mif.run = 1'b1;
    tick();
    mif.run = 1'b0;
  endtask

  initial begin
    logic v; logic [3:0] s; logic d;
    mif.run = 0; mif.stall = 0; mif.delay0 = 0; mif.nin = 0; mif.hold = 0; mif.length = 0;
    rst = 1'b1;
    #12;
    chk3("reset", 1'b0, 4'd0, 1'b1);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin tick(); chk3("idle", 1'b0, 4'd0, 1'b1); end

    // basic: delay0=3 nin=3 hold=1 length=10; input changes after run must be ignored
    start(3, 3, 1, 10);
    mif.delay0 = 0; mif.nin = 15; mif.hold = 0; mif.length = 1;
    for (int c = 1; c <= 14; c++) begin
      v = (c >= 4 && c <= 13);
      s = v ? 4'(((c - 4) / 2) % 4) : (c < 4 ? 4'd0 : 4'd1);
      d = (c >= 14);
      chk3($sformatf("basic.c%0d", c), v, s, d);
      tick();
    end

    // stall and wrap: stall sampled on the edges ending cycles 6 and 7
    start(0, 15, 0, 20);
    for (int c = 1; c <= 23; c++) begin
      if (c <= 6)       begin v = 1; s = 4'(c - 1); d = 0; end
      else if (c <= 8)  begin v = 0; s = 4'd5;      d = 0; end
      else if (c <= 22) begin v = 1; s = 4'((c - 3) % 16); d = 0; end
      else              begin v = 0; s = 4'd4;      d = 1; end
      chk3($sformatf("stall.c%0d", c), v, s, d);
      if (c == 6) mif.stall = 1'b1;
      if (c == 8) mif.stall = 1'b0;
      tick();
    end

    // restart during slot 4 of a running schedule
    start(0, 3, 0, 10);
    for (int c = 1; c <= 5; c++) begin
      chk3($sformatf("pre.c%0d", c), 1'b1, 4'((c - 1) % 4), 1'b0);
      if (c < 5) tick();
    end
    start(0, 1, 0, 3);
    for (int c = 1; c <= 4; c++) begin
      v = (c <= 3);
      s = (c == 2 || c == 4) ? 4'd1 : 4'd0;
      chk3($sformatf("restart.c%0d", c), v, s, !v);
      tick();
    end

    // length=0 with delay0=0: nothing happens
    start(0, 2, 0, 0);
    for (int c = 1; c <= 4; c++) begin chk3($sformatf("len0.c%0d", c), 1'b0, 4'd0, 1'b1); tick(); end
    // length=0 with delay0=2: done low for 2 cycles, no slot
    start(2, 2, 0, 0);
    for (int c = 1; c <= 4; c++) begin chk3($sformatf("len0d.c%0d", c), 1'b0, 4'd0, c > 2); tick(); end
    // nin=0 hold=255 length=256
    start(0, 0, 255, 256);
    for (int c = 1; c <= 257; c++) begin
      v = (c <= 256);
      chk3($sformatf("long.c%0d", c), v, 4'd0, !v);
      tick();
    end

    // async reset in the middle of DELAY
    start(5, 3, 0, 4);
    tick();
    chk3("mid.delay", 1'b0, 4'd0, 1'b0);
    #2 rst = 1'b1;
    #1 chk3("arst.delay", 1'b0, 4'd0, 1'b1);
    #1 rst = 1'b0;
    tick();
    chk3("post.arst.delay", 1'b0, 4'd0, 1'b1);

    // async reset in the middle of ACTIVE
    start(0, 3, 0, 10);
    tick(); tick();
    chk3("mid.active", 1'b1, 4'd2, 1'b0);
    #2 rst = 1'b1;
    #1 chk3("arst.active", 1'b0, 4'd0, 1'b1);
    #1 rst = 1'b0;
    tick();
    chk3("post.arst.active", 1'b0, 4'd0, 1'b1);

    // fresh run after reset behaves as from power-up
    start(1, 2, 0, 3);
    for (int c = 1; c <= 5; c++) begin
      v = (c >= 2 && c <= 4);
      s = v ? 4'(c - 2) : 4'd0;
      chk3($sformatf("fresh.c%0d", c), v, s, c == 5);
      tick();
    end

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
